apb_slave_responder: RTL and testbench



---
 rtl/bridge_pkg.sv | 13 +
 rtl/apb_slave_responder_if.sv | 16 +
 rtl/apb_protocol_checker.sv | 58 +++++
 rtl/apb_slave_responder.sv | 121 ++++++++++++
 tb/tb_apb_slave_responder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bridge_pkg.sv
// Shared AHB-APB bridge definitions: bus widths, APB phase tracker states and
// the width of the protocol-violation counter.
package bridge_pkg;
  localparam int WIDTH     = 32;
  localparam int SLAVES    = 4;
  localparam int ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;
endpackage

// File: rtl/apb_slave_responder_if.sv
// APB bus between the bridge (master) and its completers (slave).
// There is no PREADY: every transfer is zero wait state.
interface apb_slave_responder_if #(
  parameter int WIDTH  = 32,
  parameter int SLAVES = 4
);
  logic [SLAVES-1:0] Pselx;
  logic              Penable;
  logic              Pwrite;
  logic [WIDTH-1:0]  Paddr;
  logic [WIDTH-1:0]  Pwdata;
  logic [WIDTH-1:0]  Prdata;

  modport master (output Pselx, Penable, Pwrite, Paddr, Pwdata, input Prdata);
  modport slave  (input Pselx, Penable, Pwrite, Paddr, Pwdata, output Prdata);
endinterface

// File: rtl/apb_protocol_checker.sv
// Flags APB protocol violations seen by the responder; sticky flag plus a
// saturating count, one increment per offending cycle.
module apb_protocol_checker
  import bridge_pkg::*;
#(
  parameter int WIDTH = bridge_pkg::WIDTH
) (
  input  logic                 clock,
  input  logic                 Hresetn,
  input  apb_state_e           state,
  input  logic                 capture,
  input  logic                 sel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [WIDTH-1:0]     paddr,
  input  logic [WIDTH-1:0]     pwdata,
  output logic                 viol,
  output logic                 prot_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             wr_q;

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (capture) begin
      addr_q  <= paddr;
      wdata_q <= pwdata;
      wr_q    <= pwrite;
    end
  end

  // While the tracker sits in SETUP the bus is in its ACCESS cycle, so that is
  // where the setup-phase attributes must still hold and sel must stay high.
  always_comb begin
    viol = 1'b0;
    if (state == IDLE && penable)
      viol = 1'b1;
    if (state == SETUP &&
        (!sel || paddr != addr_q || pwrite != wr_q || pwdata != wdata_q))
      viol = 1'b1;
  end

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      prot_err  <= 1'b0;
      err_count <= '0;
    end else if (viol) begin
      prot_err <= 1'b1;
      if (err_count != {ERR_CNT_W{1'b1}})
        err_count <= err_count + ERR_CNT_W'(1);
    end
  end
endmodule

// File: rtl/apb_slave_responder.sv
// Zero-wait-state APB completer with a word-addressed register file.
// Optional protocol checker enabled by APB_PROTOCOL_CHECK_EN.
module apb_slave_responder
  import bridge_pkg::*;
#(
  parameter int WIDTH     = bridge_pkg::WIDTH,
  parameter int SLAVES    = bridge_pkg::SLAVES,
  parameter int SLAVE_IDX = 0,
  parameter int DEPTH     = 16
) (
  input  logic                 clock,
  input  logic                 Hresetn,
  apb_slave_responder_if.slave apb,
  output logic                 wr_done,
  output logic                 rd_done,
  output logic                 prot_err,
  output logic [ERR_CNT_W-1:0] err_count
);
  localparam int AW = $clog2(DEPTH);

  apb_state_e       state, next_state;
  logic             sel;
  logic             capture;
  logic             viol;
  logic [AW-1:0]    idx_q;
  logic [WIDTH-1:0] wdata_q;
  logic             wr_q;
  logic             drop_q;
  logic [WIDTH-1:0] prdata_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             unused_bits;

  assign sel         = apb.Pselx[SLAVE_IDX];
  assign capture     = (next_state == SETUP);
  assign apb.Prdata  = prdata_q;
  assign unused_bits = ^{apb.Pselx, apb.Paddr};

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) state <= IDLE;
    else          state <= next_state;
  end

  // The state names the bus phase sampled at the previous edge.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    if (sel && !apb.Penable) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (sel && !apb.Penable) next_state = SETUP;
      default: next_state = IDLE;
    endcase
  end

  // Transfer attributes are latched from the setup phase so a back-to-back
  // successor on the bus cannot disturb the commit one edge later.
  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      idx_q   <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else if (capture) begin
      idx_q   <= apb.Paddr[AW+1:2];
      wdata_q <= apb.Pwdata;
      wr_q    <= apb.Pwrite;
      drop_q  <= 1'b0;
    end else if (state == SETUP && viol) begin
      drop_q  <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      prdata_q <= '0;
      wr_done  <= 1'b0;
      rd_done  <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      if (state == SETUP && !wr_q) begin
        prdata_q <= mem[idx_q];
      end else if (state == ACCESS) begin
        prdata_q <= '0;
        wr_done  <= wr_q && !drop_q;
        rd_done  <= !wr_q;
      end
    end
  end

  always_ff @(posedge clock or negedge Hresetn) begin
    if (!Hresetn) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (state == ACCESS && wr_q && !drop_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

`ifdef APB_PROTOCOL_CHECK_EN
  apb_protocol_checker #(
    .WIDTH (WIDTH)
  ) u_checker (
    .clock     (clock),
    .Hresetn   (Hresetn),
    .state     (state),
    .capture   (capture),
    .sel       (sel),
    .penable   (apb.Penable),
    .pwrite    (apb.Pwrite),
    .paddr     (apb.Paddr),
    .pwdata    (apb.Pwdata),
    .viol      (viol),
    .prot_err  (prot_err),
    .err_count (err_count)
  );
`else
  assign viol      = 1'b0;
  assign prot_err  = 1'b0;
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_apb_slave_responder.sv
// Bench for apb_slave_responder: transfer lists are expanded into per-cycle
// expected outputs from a word-array model of the register file.
module tb_apb_slave_responder;
  import bridge_pkg::*;

  localparam int DEPTH = 16;
  localparam int SIDX  = 2;
  localparam logic [3:0] SEL = 4'(1 << SIDX);

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          gap;
  } xfer_t;

  logic       clock = 1'b0;
  logic       Hresetn = 1'b0;
  logic       wr_done, rd_done, prot_err;
  logic [7:0] err_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] mmem [DEPTH];
  int          model_err = 0;
  bit          model_prot = 1'b0;
  xfer_t       xq [$];

  always #5 clock = ~clock;

  apb_slave_responder_if #(.WIDTH(32), .SLAVES(4)) bus ();

  apb_slave_responder #(
    .WIDTH(32), .SLAVES(4), .SLAVE_IDX(SIDX), .DEPTH(DEPTH)
  ) dut (
    .clock     (clock),
    .Hresetn   (Hresetn),
    .apb       (bus),
    .wr_done   (wr_done),
    .rd_done   (rd_done),
    .prot_err  (prot_err),
    .err_count (err_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_bus(input logic [3:0] psel, input logic en, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
    bus.Pselx   = psel;
    bus.Penable = en;
    bus.Pwrite  = wr;
    bus.Paddr   = a;
    bus.Pwdata  = d;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
    model_err  = 0;
    model_prot = 1'b0;
  endtask

  task automatic run_xfers(input string tag);
    int          starts [$];
    int          c, total, s, idx;
    logic [31:0] e_prd [];
    bit          e_wr [], e_rd [];
    logic [3:0]  d_sel [];
    bit          d_en [], d_wr [];
    logic [31:0] d_a [], d_d [];
    c = 0;
    foreach (xq[i]) begin
      starts.push_back(c);
      c = c + 2 + xq[i].gap;
    end
    total = c + 3;
    e_prd = new[total]; e_wr = new[total]; e_rd = new[total];
    d_sel = new[total]; d_en = new[total]; d_wr = new[total];
    d_a = new[total]; d_d = new[total];
    for (int k = 0; k < total; k++) begin
      e_prd[k] = '0; e_wr[k] = 1'b0; e_rd[k] = 1'b0;
      d_sel[k] = 4'($urandom) & ~SEL;
      d_en[k]  = 1'b0;
      d_wr[k]  = 1'($urandom);
      d_a[k]   = $urandom;
      d_d[k]   = $urandom;
    end
    foreach (xq[i]) begin
      s = starts[i];
      for (int p = 0; p < 2; p++) begin
        d_sel[s+p] = SEL;
        d_en[s+p]  = (p == 1);
        d_wr[s+p]  = xq[i].wr;
        d_a[s+p]   = xq[i].addr;
        d_d[s+p]   = xq[i].data;
      end
      idx = int'((xq[i].addr >> 2) % DEPTH);
      if (xq[i].wr) begin
        mmem[idx] = xq[i].data;
        e_wr[s+3] = 1'b1;
      end else begin
        e_prd[s+2] = mmem[idx];
        e_rd[s+3]  = 1'b1;
      end
    end
    for (int k = 0; k < total; k++) begin
      set_bus(d_sel[k], d_en[k], d_wr[k], d_a[k], d_d[k]);
      n_checks++;
      if (bus.Prdata !== e_prd[k]) begin
        n_fail++;
        $display("FAIL %s prdata cyc %0d: got %h want %h", tag, k, bus.Prdata, e_prd[k]);
      end
      n_checks++;
      if (wr_done !== e_wr[k]) begin
        n_fail++;
        $display("FAIL %s wr_done cyc %0d: got %b want %b", tag, k, wr_done, e_wr[k]);
      end
      n_checks++;
      if (rd_done !== e_rd[k]) begin
        n_fail++;
        $display("FAIL %s rd_done cyc %0d: got %b want %b", tag, k, rd_done, e_rd[k]);
      end
      n_checks++;
      if (prot_err !== model_prot || err_count !== 8'(model_err)) begin
        n_fail++;
        $display("FAIL %s err cyc %0d: got %b/%0d want %b/%0d", tag, k,
                 prot_err, err_count, model_prot, model_err);
      end
      tick();
    end
    set_bus(4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    xq.delete();
  endtask

  task automatic test_reset();
    clear_model();
    set_bus(4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    Hresetn = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus.Prdata, wr_done, rd_done, prot_err, err_count} !== 43'h0) begin
      n_fail++;
      $display("FAIL reset_held: got prdata %h wr %b rd %b perr %b cnt %0d want all 0",
               bus.Prdata, wr_done, rd_done, prot_err, err_count);
    end
    Hresetn = 1'b1;
    tick();
    n_checks++;
    if ({bus.Prdata, wr_done, rd_done, prot_err, err_count} !== 43'h0) begin
      n_fail++;
      $display("FAIL reset_released: got prdata %h wr %b rd %b perr %b cnt %0d want all 0",
               bus.Prdata, wr_done, rd_done, prot_err, err_count);
    end
    xq.push_back('{wr: 1'b0, addr: 32'h0, data: 32'h0, gap: 1});
    run_xfers("reset_read0");
  endtask

  task automatic test_write_read();
    xq.push_back('{wr: 1'b1, addr: 32'h8, data: 32'hDEADBEEF, gap: 1});
    xq.push_back('{wr: 1'b0, addr: 32'h8, data: 32'h0, gap: 1});
    run_xfers("write_read");
  endtask

  task automatic test_alias();
    xq.push_back('{wr: 1'b1, addr: 32'h44, data: 32'h11, gap: 0});
    xq.push_back('{wr: 1'b0, addr: 32'h04, data: 32'h0, gap: 2});
    xq.push_back('{wr: 1'b0, addr: 32'hFFFF_FF47, data: 32'h0, gap: 1});
    run_xfers("alias");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    for (int i = 0; i < 4; i++) begin
      a[i] = ($urandom & 32'hFFFF_FFC0) | 32'(i * 4 + 16);
      xq.push_back('{wr: 1'b1, addr: a[i], data: $urandom, gap: 0});
    end
    for (int i = 0; i < 4; i++)
      xq.push_back('{wr: 1'b0, addr: a[i], data: 32'h0, gap: 0});
    run_xfers("back_to_back");
  endtask

  task automatic test_random();
    for (int i = 0; i < 48; i++)
      xq.push_back('{wr: 1'($urandom), addr: $urandom, data: $urandom,
                     gap: int'($urandom_range(0, 2))});
    run_xfers("random");
  endtask

`ifdef APB_PROTOCOL_CHECK_EN
  task automatic test_violations();
    // Paddr moves between setup and access: write dropped, one violation.
    set_bus(SEL, 1'b0, 1'b1, 32'h10, 32'h55); tick();
    set_bus(SEL, 1'b1, 1'b1, 32'h14, 32'h55); tick();
    model_err = 1; model_prot = 1'b1;
    n_checks++;
    if (prot_err !== 1'b1 || err_count !== 8'd1) begin
      n_fail++;
      $display("FAIL addr_change_err: got %b/%0d want 1/1", prot_err, err_count);
    end
    set_bus(4'h0, 1'b0, 1'b0, 32'h0, 32'h0); tick();
    n_checks++;
    if (wr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL addr_change_wr_done: got %b want 0", wr_done);
    end
    // sel drops during access: also dropped and counted.
    set_bus(SEL, 1'b0, 1'b1, 32'h18, 32'h66); tick();
    set_bus(4'h0, 1'b1, 1'b1, 32'h18, 32'h66); tick();
    model_err = 2;
    set_bus(4'h0, 1'b0, 1'b0, 32'h0, 32'h0); tick();
    n_checks++;
    if (wr_done !== 1'b0 || err_count !== 8'd2) begin
      n_fail++;
      $display("FAIL sel_drop: got wr %b cnt %0d want 0/2", wr_done, err_count);
    end
    tick();
    xq.push_back('{wr: 1'b0, addr: 32'h10, data: 32'h0, gap: 0});
    xq.push_back('{wr: 1'b0, addr: 32'h14, data: 32'h0, gap: 0});
    xq.push_back('{wr: 1'b0, addr: 32'h18, data: 32'h0, gap: 1});
    run_xfers("viol_readback");
    for (int k = 0; k < 300; k++) begin
      set_bus(4'h0, 1'b1, 1'b0, 32'h0, 32'h0);
      tick();
      model_err = (model_err < 255) ? model_err + 1 : 255;
      n_checks++;
      if (err_count !== 8'(model_err) || prot_err !== 1'b1) begin
        n_fail++;
        $display("FAIL saturate k=%0d: got %b/%0d want 1/%0d", k, prot_err, err_count, model_err);
      end
    end
    set_bus(4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask
`endif

  task automatic test_reset_mid_write();
    set_bus(SEL, 1'b0, 1'b1, 32'h20, 32'hAA); tick();
    set_bus(SEL, 1'b1, 1'b1, 32'h20, 32'hAA); tick();
    set_bus(4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 Hresetn = 1'b0;
    #1;
    n_checks++;
    if (wr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midwrite_in_reset: wr_done got %b want 0", wr_done);
    end
    tick(); tick();
    Hresetn = 1'b1;
    clear_model();
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wr_done !== 1'b0) begin
        n_fail++;
        $display("FAIL midwrite_after_reset cyc %0d: wr_done got %b want 0", k, wr_done);
      end
      tick();
    end
    xq.push_back('{wr: 1'b0, addr: 32'h20, data: 32'h0, gap: 0});
    xq.push_back('{wr: 1'b0, addr: 32'h8, data: 32'h0, gap: 1});
    run_xfers("midwrite_readback");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alias();
    test_back_to_back();
    test_random();
`ifdef APB_PROTOCOL_CHECK_EN
    test_violations();
`endif
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
